// File: rtl/key_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// key_cmd_ctrl
// Turns the raw 3-bit button code into game commands. The code is
// synchronized, debounced and edge-detected. Direction buttons (codes 0-3)
// auto-repeat while they are held. One-shot buttons (codes 4-6) fire once.
// Commands go out through a one-deep valid/ready register.
//
// Ports
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   code[2:0]   : encoded button code, asynchronous to clk (7 = no button)
//   cmd_ready   : consumer accepts the pending command this cycle
//   cmd_valid   : a command is pending (registered)
//   cmd_code    : pending command code, held while cmd_valid (registered)
//   cmd_dropped : one-cycle pulse per discarded or overwritten event (registered)
// -----------------------------------------------------------------------------
module key_cmd_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_RATE     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       cmd_dropped
);

  localparam logic [2:0]  CODE_NONE    = 3'd7;
  localparam logic [7:0]  DB_TARGET    = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0] DELAY_TARGET = 16'(REPEAT_DELAY);
  localparam logic [15:0] RATE_TARGET  = 16'(REPEAT_RATE);

  typedef enum logic [1:0] {
    IDLE,
    ONESHOT,
    HOLD_DELAY,
    HOLD_REPEAT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  sync_a;
  logic [2:0]  sync_b;
  logic [2:0]  cand;
  logic [7:0]  db_cnt;
  logic [2:0]  deb;
  logic [2:0]  deb_prev;
  logic [15:0] timer;
  logic        press;
  logic        rep_fire;
  logic        ev;
  logic [2:0]  ev_code;
  logic        hold_next;

  // Two-flop synchronizer. Both stages reset to the "no button" code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= CODE_NONE;
      sync_b <= CODE_NONE;
    end else begin
      sync_a <= code;
      sync_b <= sync_a;
    end
  end

  // Debounce. cand tracks the current run of the synchronized code, and
  // db_cnt counts how long that run has lasted, saturating at the target.
  // deb takes the candidate on the cycle the run reaches the target length.
  // deb_prev delays deb by one cycle so that changes can be edge-detected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand     <= CODE_NONE;
      db_cnt   <= 8'd0;
      deb      <= CODE_NONE;
      deb_prev <= CODE_NONE;
    end else begin
      deb_prev <= deb;
      if (sync_b != cand) begin
        cand   <= sync_b;
        db_cnt <= 8'd1;
        if (DB_TARGET == 8'd1) begin
          deb <= sync_b;
        end
      end else if (db_cnt < DB_TARGET) begin
        db_cnt <= db_cnt + 8'd1;
        if (db_cnt + 8'd1 == DB_TARGET) begin
          deb <= cand;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A release returns to IDLE from any state. A new press,
  // including a direct change between two buttons, restarts according to
  // the class of the new code.
  always_comb begin
    state_next = state;
    if (deb == CODE_NONE) begin
      state_next = IDLE;
    end else if (press) begin
      state_next = deb[2] ? ONESHOT : HOLD_DELAY;
    end else if (state == HOLD_DELAY && rep_fire) begin
      state_next = HOLD_REPEAT;
    end
  end

  // Event generation. A press is any debounced change to a real button.
  // A repeat fires when the hold timer reaches the delay or rate target.
  // A press takes priority, and a release suppresses a repeat that would
  // otherwise fire in the same cycle.
  always_comb begin
    press    = (deb != deb_prev) && (deb != CODE_NONE);
    rep_fire = 1'b0;
    if (deb != CODE_NONE && !press) begin
      case (state)
        HOLD_DELAY:  rep_fire = (timer == DELAY_TARGET);
        HOLD_REPEAT: rep_fire = (timer == RATE_TARGET);
        default:     rep_fire = 1'b0;
      endcase
    end
    ev        = press | rep_fire;
    ev_code   = deb;
    hold_next = (state_next == HOLD_DELAY) || (state_next == HOLD_REPEAT);
  end

  // Hold timer. It restarts at 1 on every event while a direction is held,
  // so it counts cycles since the last press or repeat. It ignores
  // cmd_ready, so backpressure never shifts the repeat timing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= 16'd0;
    end else if (!hold_next) begin
      timer <= 16'd0;
    end else if (ev) begin
      timer <= 16'd1;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  // One-deep command register. An event is loaded if the slot is free or is
  // being accepted this cycle. Otherwise the event is dropped. The exception
  // is a reset_red or reset_blue event that meets a pending code of 0-4:
  // the reset code replaces the pending code. Either way, cmd_dropped pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_valid   <= 1'b0;
      cmd_code    <= CODE_NONE;
      cmd_dropped <= 1'b0;
    end else begin
      cmd_dropped <= 1'b0;
      if (ev) begin
        if (!cmd_valid || cmd_ready) begin
          cmd_valid <= 1'b1;
          cmd_code  <= ev_code;
        end else begin
          cmd_dropped <= 1'b1;
          if ((ev_code == 3'd5 || ev_code == 3'd6) && cmd_code <= 3'd4) begin
            cmd_code <= ev_code;
          end
        end
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule
